// File: rtl/mult_arbiter.sv
// Round-robin front end that shares one pipelined multiplier among NUM_REQ requesters.
// Issued requester ids travel a tag pipeline aligned with the multiplier latency to route results.
module mult_arbiter #(
    parameter int unsigned WL      = 32,
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned MUL_LAT = 4
) (
    input  logic                         clk_i,
    input  logic                         reset_ni,
    input  logic [NUM_REQ-1:0]           req_valid_i,
    output logic [NUM_REQ-1:0]           req_ready_o,
    input  logic [NUM_REQ*WL-1:0]        req_a_i,
    input  logic [NUM_REQ*WL-1:0]        req_b_i,
    output logic [NUM_REQ-1:0]           rsp_valid_o,
    output logic [2*WL-1:0]              rsp_product_o,
    output logic                         mul_start_o,
    output logic [WL-1:0]                mul_multiplier_o,
    output logic [WL-1:0]                mul_multiplicand_o,
    input  logic                         mul_done_i,
    input  logic [2*WL-1:0]              mul_product_i,
    output logic [$clog2(MUL_LAT+1)-1:0] inflight_o,
    output logic                         seq_error_o
);

    localparam int unsigned IdxW = $clog2(NUM_REQ);
    localparam int unsigned CntW = $clog2(MUL_LAT + 1);

    logic [IdxW-1:0]    ptr_q, ptr_d;
    logic               gnt_found;
    logic [IdxW-1:0]    gnt_idx;
    logic [IdxW:0]      cand_sum;
    logic               gnt_en;

    logic [MUL_LAT-1:0] tag_vld_q;
    logic [IdxW-1:0]    tag_id_q [MUL_LAT];
    logic               last_vld;
    logic [IdxW-1:0]    last_id;
    logic               rsp_fire;

    logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [2*WL-1:0]    rsp_product_q, rsp_product_d;
    logic [CntW-1:0]    inflight_q, inflight_d;
    logic               seq_err_q, seq_err_d;

    // Scan requesters starting at ptr_q, wrapping modulo NUM_REQ; first valid one wins.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand_sum  = '0;
        for (int k = 0; k < int'(NUM_REQ); k++) begin
            cand_sum = {1'b0, ptr_q} + (IdxW+1)'(k);
            if (cand_sum >= (IdxW+1)'(NUM_REQ)) begin
                cand_sum = cand_sum - (IdxW+1)'(NUM_REQ);
            end
            if (!gnt_found && req_valid_i[cand_sum[IdxW-1:0]]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand_sum[IdxW-1:0];
            end
        end
    end

    // Grant is suppressed combinationally while reset is held.
    assign gnt_en = gnt_found & reset_ni;

    always_comb begin
        req_ready_o        = '0;
        mul_multiplier_o   = '0;
        mul_multiplicand_o = '0;
        if (gnt_en) begin
            req_ready_o        = NUM_REQ'(1) << gnt_idx;
            mul_multiplier_o   = req_a_i[32'(gnt_idx)*WL +: WL];
            mul_multiplicand_o = req_b_i[32'(gnt_idx)*WL +: WL];
        end
    end

    assign mul_start_o = gnt_en;

    always_comb begin
        ptr_d = ptr_q;
        if (gnt_en) begin
            ptr_d = (gnt_idx == IdxW'(NUM_REQ - 1)) ? '0 : gnt_idx + IdxW'(1);
        end
    end

    assign last_vld = tag_vld_q[MUL_LAT-1];
    assign last_id  = tag_id_q[MUL_LAT-1];
    assign rsp_fire = last_vld & mul_done_i;

    always_comb begin
        rsp_valid_d   = '0;
        rsp_product_d = rsp_product_q;
        if (rsp_fire) begin
            rsp_valid_d   = NUM_REQ'(1) << last_id;
            rsp_product_d = mul_product_i;
        end
    end

    // A tag leaving the last stage retires the operation whether or not the multiplier answered.
    always_comb begin
        inflight_d = inflight_q;
        case ({mul_start_o, last_vld})
            2'b10:   inflight_d = inflight_q + CntW'(1);
            2'b01:   inflight_d = inflight_q - CntW'(1);
            default: inflight_d = inflight_q;
        endcase
    end

    assign seq_err_d = seq_err_q | (mul_done_i ^ last_vld);

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            ptr_q         <= '0;
            tag_vld_q     <= '0;
            for (int k = 0; k < int'(MUL_LAT); k++) begin
                tag_id_q[k] <= '0;
            end
            rsp_valid_q   <= '0;
            rsp_product_q <= '0;
            inflight_q    <= '0;
            seq_err_q     <= 1'b0;
        end else begin
            ptr_q         <= ptr_d;
            tag_vld_q     <= {tag_vld_q[MUL_LAT-2:0], mul_start_o};
            tag_id_q[0]   <= gnt_idx;
            for (int k = 1; k < int'(MUL_LAT); k++) begin
                tag_id_q[k] <= tag_id_q[k-1];
            end
            rsp_valid_q   <= rsp_valid_d;
            rsp_product_q <= rsp_product_d;
            inflight_q    <= inflight_d;
            seq_err_q     <= seq_err_d;
        end
    end

    assign rsp_valid_o   = rsp_valid_q;
    assign rsp_product_o = rsp_product_q;
    assign inflight_o    = inflight_q;
    assign seq_error_o   = seq_err_q;

    a_grant_onehot: assert property (@(posedge clk_i) disable iff (!reset_ni)
        $onehot0(req_ready_o) && ((req_ready_o & ~req_valid_i) == '0));
    a_inflight_max: assert property (@(posedge clk_i) disable iff (!reset_ni)
        inflight_q <= CntW'(MUL_LAT));

endmodule

// File: tb/tb_mult_arbiter.sv
// Directed bench for mult_arbiter with a behavioural fixed-latency multiplier model.
module tb_mult_arbiter;

    localparam int unsigned WL = 32;
    localparam int unsigned N  = 4;
    localparam int unsigned L  = 4;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [N*WL-1:0]   req_a;
    logic [N*WL-1:0]   req_b;
    logic [N-1:0]      rsp_valid;
    logic [2*WL-1:0]   rsp_product;
    logic              mul_start;
    logic [WL-1:0]     mul_multiplier;
    logic [WL-1:0]     mul_multiplicand;
    logic              mul_done;
    logic [2*WL-1:0]   mul_product;
    logic [2:0]        inflight;
    logic              seq_error;

    logic              force_done;
    logic              suppress_done;
    logic [L:1]        m_vld;
    logic [2*WL-1:0]   m_prod [1:L];

    int n_checks = 0;
    int n_fail   = 0;

    logic [3:0]  exp_gnt  [6] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
    logic [63:0] exp_prod [6] = '{64'd20, 64'd33, 64'd48, 64'd65, 64'd20, 64'd33};
    logic [3:0]  seen;

    always #5 clk = ~clk;

    mult_arbiter #(.WL(WL), .NUM_REQ(N), .MUL_LAT(L)) dut (
        .clk_i              (clk),
        .reset_ni           (reset_n),
        .req_valid_i        (req_valid),
        .req_ready_o        (req_ready),
        .req_a_i            (req_a),
        .req_b_i            (req_b),
        .rsp_valid_o        (rsp_valid),
        .rsp_product_o      (rsp_product),
        .mul_start_o        (mul_start),
        .mul_multiplier_o   (mul_multiplier),
        .mul_multiplicand_o (mul_multiplicand),
        .mul_done_i         (mul_done),
        .mul_product_i      (mul_product),
        .inflight_o         (inflight),
        .seq_error_o        (seq_error)
    );

    // Multiplier model shares the block's reset, so a reset flushes it too.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_vld <= '0;
            for (int k = 1; k <= int'(L); k++) m_prod[k] <= '0;
        end else begin
            m_vld     <= {m_vld[L-1:1], mul_start};
            m_prod[1] <= 64'(mul_multiplier) * 64'(mul_multiplicand);
            for (int k = 2; k <= int'(L); k++) m_prod[k] <= m_prod[k-1];
        end
    end

    assign mul_done    = (m_vld[L] & ~suppress_done) | force_done;
    assign mul_product = m_prod[L];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_ops(input int i, input logic [31:0] a, input logic [31:0] b);
        req_a[i*32 +: 32] = a;
        req_b[i*32 +: 32] = b;
    endtask

    initial begin
        reset_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0;
        force_done = 1'b0; suppress_done = 1'b0;
        repeat (2) @(negedge clk);
        req_valid = 4'hF; #1;
        check("rst_ready", 64'(req_ready), 64'd0);
        check("rst_start", 64'(mul_start), 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_rsp_product", rsp_product, 64'd0);
        check("rst_inflight", 64'(inflight), 64'd0);
        check("rst_seq_error", 64'(seq_error), 64'd0);

        // Single request in the first cycle after reset release.
        @(negedge clk); reset_n = 1'b1; req_valid = 4'b0100; set_ops(2, 3, 7); #1;
        check("single_ready", 64'(req_ready), 64'b0100);
        check("single_start", 64'(mul_start), 64'd1);
        check("single_mplier", 64'(mul_multiplier), 64'd3);
        check("single_mcand", 64'(mul_multiplicand), 64'd7);
        @(negedge clk); req_valid = '0; #1;
        check("single_inflight1", 64'(inflight), 64'd1);
        check("idle_mplier_zero", 64'(mul_multiplier), 64'd0);
        repeat (3) @(negedge clk); #1;
        check("single_rsp_early", 64'(rsp_valid), 64'd0);
        @(negedge clk); #1;
        check("single_rsp_valid", 64'(rsp_valid), 64'b0100);
        check("single_rsp_prod", rsp_product, 64'd21);
        check("single_inflight0", 64'(inflight), 64'd0);
        @(negedge clk); #1;
        check("single_rsp_pulse", 64'(rsp_valid), 64'd0);
        check("single_prod_hold", rsp_product, 64'd21);

        // ptr is 3 here: search wraps to 0, then continues to 1.
        @(negedge clk); req_valid = 4'b0011; set_ops(0, 5, 6); set_ops(1, 9, 11); #1;
        check("wrap_ready0", 64'(req_ready), 64'b0001);
        check("wrap_mplier0", 64'(mul_multiplier), 64'd5);
        @(negedge clk); #1;
        check("wrap_ready1", 64'(req_ready), 64'b0010);
        check("wrap_mcand1", 64'(mul_multiplicand), 64'd11);
        @(negedge clk); req_valid = '0; #1;
        check("wrap_idle_ready", 64'(req_ready), 64'd0);
        check("wrap_idle_start", 64'(mul_start), 64'd0);
        repeat (3) @(negedge clk); #1;
        check("wrap_rsp0", 64'(rsp_valid), 64'b0001);
        check("wrap_prod0", rsp_product, 64'd30);
        @(negedge clk); #1;
        check("wrap_rsp1", 64'(rsp_valid), 64'b0010);
        check("wrap_prod1", rsp_product, 64'd99);
        @(negedge clk); #1;
        check("wrap_rsp_end", 64'(rsp_valid), 64'd0);
        check("wrap_inflight", 64'(inflight), 64'd0);

        // Width corner; ptr is 2 so requester 0 wins via wrap.
        @(negedge clk); req_valid = 4'b0001; set_ops(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF); #1;
        check("wide_ready", 64'(req_ready), 64'b0001);
        @(negedge clk); req_valid = '0;
        repeat (4) @(negedge clk); #1;
        check("wide_rsp", 64'(rsp_valid), 64'b0001);
        check("wide_prod", rsp_product, 64'hFFFF_FFFE_0000_0001);

        // All requesters valid continuously from reset.
        @(negedge clk); reset_n = 1'b0; #1;
        check("rr_rst_inflight", 64'(inflight), 64'd0);
        @(negedge clk); reset_n = 1'b1; req_valid = 4'hF;
        for (int i = 0; i < 4; i++) set_ops(i, 32'(i + 2), 32'(i + 10));
        #1;
        check("rr_gnt0", 64'(req_ready), 64'(exp_gnt[0]));
        for (int c = 1; c < 6; c++) begin
            @(negedge clk); #1;
            check("rr_gnt", 64'(req_ready), 64'(exp_gnt[c]));
            if (c == 4) check("rr_inflight_full", 64'(inflight), 64'd4);
        end
        check("rr_rsp0", 64'(rsp_valid), 64'(exp_gnt[0]));
        check("rr_prod0", rsp_product, exp_prod[0]);
        check("rr_inflight_c5", 64'(inflight), 64'd4);
        @(negedge clk); req_valid = '0;
        for (int c = 1; c < 6; c++) begin
            if (c > 1) @(negedge clk);
            #1;
            check("rr_rsp", 64'(rsp_valid), 64'(exp_gnt[c]));
            check("rr_prod", rsp_product, exp_prod[c]);
        end
        @(negedge clk); #1;
        check("rr_rsp_end", 64'(rsp_valid), 64'd0);
        check("rr_inflight_end", 64'(inflight), 64'd0);
        check("rr_seq_error", 64'(seq_error), 64'd0);

        // Three issues, then reset with the multiplier reset alongside.
        @(negedge clk); req_valid = 4'b0001; set_ops(0, 7, 8); #1;
        check("mid_ready", 64'(req_ready), 64'b0001);
        repeat (2) @(negedge clk); #1;
        check("mid_inflight", 64'(inflight), 64'd2);
        @(negedge clk); req_valid = '0; reset_n = 1'b0; #1;
        check("mid_rst_inflight", 64'(inflight), 64'd0);
        @(negedge clk); reset_n = 1'b1;
        seen = '0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk); #1;
            seen = seen | rsp_valid;
        end
        check("mid_no_rsp", 64'(seen), 64'd0);
        check("mid_inflight_end", 64'(inflight), 64'd0);
        check("mid_seq_error", 64'(seq_error), 64'd0);

        // Spurious done with nothing in flight.
        @(negedge clk); force_done = 1'b1; #1;
        @(negedge clk); force_done = 1'b0; #1;
        check("spur_seq_error", 64'(seq_error), 64'd1);
        check("spur_rsp", 64'(rsp_valid), 64'd0);
        seen = '0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); #1;
            seen = seen | rsp_valid;
        end
        check("spur_sticky", 64'(seq_error), 64'd1);
        check("spur_no_rsp", 64'(seen), 64'd0);
        @(negedge clk); reset_n = 1'b0; #1;
        check("spur_rst_clear", 64'(seq_error), 64'd0);

        // Missing done: tag dropped, error raised, count retired.
        @(negedge clk); reset_n = 1'b1; suppress_done = 1'b1;
        req_valid = 4'b0001; set_ops(0, 2, 2); #1;
        check("miss_ready", 64'(req_ready), 64'b0001);
        @(negedge clk); req_valid = '0;
        repeat (3) @(negedge clk); #1;
        check("miss_no_err_yet", 64'(seq_error), 64'd0);
        @(negedge clk); #1;
        check("miss_seq_error", 64'(seq_error), 64'd1);
        check("miss_inflight", 64'(inflight), 64'd0);
        check("miss_rsp", 64'(rsp_valid), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
